// File: rtl/enemy_move_square.sv
// Enemy sprite position/state tracker: once-per-frame right/left/descend sweep with
// death, respawn and landing, plus a registered per-pixel inside flag and sprite offsets.
module enemy_move_square #(
  parameter int unsigned OBJECT_WIDTH_X = 11,
  parameter int unsigned OBJECT_HEIGHT_Y = 48,
  parameter int unsigned INIT_X = 40,
  parameter int unsigned INIT_Y = 32,
  parameter int unsigned SPEED_X = 2,
  parameter int unsigned DROP_Y = 16,
  parameter int unsigned LEFT_LIMIT = 0,
  parameter int unsigned RIGHT_LIMIT = 639,
  parameter int unsigned BOTTOM_LIMIT = 479,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        alive,
  output logic        reachedBottom
);

  // Twelve-bit working width keeps X+W and Y+H from wrapping.
  localparam logic [11:0] W    = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0] H    = 12'(OBJECT_HEIGHT_Y);
  localparam logic [11:0] IX   = 12'(INIT_X);
  localparam logic [11:0] IY   = 12'(INIT_Y);
  localparam logic [11:0] SPD  = 12'(SPEED_X);
  localparam logic [11:0] DRP  = 12'(DROP_Y);
  localparam logic [11:0] LL   = 12'(LEFT_LIMIT);
  localparam logic [11:0] RL   = 12'(RIGHT_LIMIT);
  localparam logic [11:0] BL   = 12'(BOTTOM_LIMIT);
  localparam logic [15:0] RESP = 16'(RESPAWN_FRAMES);

  typedef enum logic [2:0] {
    MOVE_RIGHT = 3'd0,
    MOVE_LEFT  = 3'd1,
    DESCEND    = 3'd2,
    DEAD       = 3'd3,
    LANDED     = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        dir_r, dir_s;
  logic [11:0] x_r, x_s, y_r, y_s;
  logic [15:0] cnt_r, cnt_s;
  logic        alive_r, landed_r;
  logic        inside_r, inside_s;
  logic [10:0] offx_r, offy_r, dx_s, dy_s;
  logic [11:0] px_s, py_s;

  // Next-state and position update; hit overrides a coincident frame tick.
  always_comb begin
    state_s = state_r;
    dir_s   = dir_r;
    x_s     = x_r;
    y_s     = y_r;
    cnt_s   = cnt_r;
    case (state_r)
      MOVE_RIGHT: begin
        if (hit) begin
          state_s = DEAD;
          cnt_s   = RESP;
        end else if (startOfFrame) begin
          if (x_r + SPD + W - 12'd1 > RL) begin
            x_s     = RL - W + 12'd1;
            dir_s   = ~dir_r;
            state_s = DESCEND;
          end else begin
            x_s = x_r + SPD;
          end
        end else begin
          x_s = x_r;
        end
      end
      MOVE_LEFT: begin
        if (hit) begin
          state_s = DEAD;
          cnt_s   = RESP;
        end else if (startOfFrame) begin
          if (x_r < LL + SPD) begin
            x_s     = LL;
            dir_s   = ~dir_r;
            state_s = DESCEND;
          end else begin
            x_s = x_r - SPD;
          end
        end else begin
          x_s = x_r;
        end
      end
      DESCEND: begin
        if (hit) begin
          state_s = DEAD;
          cnt_s   = RESP;
        end else if (startOfFrame) begin
          if (y_r + DRP + H - 12'd1 > BL) begin
            y_s     = BL - H + 12'd1;
            state_s = LANDED;
          end else begin
            y_s     = y_r + DRP;
            state_s = dir_r ? MOVE_RIGHT : MOVE_LEFT;
          end
        end else begin
          y_s = y_r;
        end
      end
      DEAD: begin
        if (startOfFrame) begin
          if (cnt_r != 16'd0) begin
            cnt_s = cnt_r - 16'd1;
          end else begin
            x_s     = IX;
            y_s     = IY;
            dir_s   = 1'b1;
            state_s = MOVE_RIGHT;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      LANDED: begin
        state_s = LANDED;
      end
      default: begin
        state_s = MOVE_RIGHT;
      end
    endcase
  end

  // Pixel hit test against the current (pre-update) position.
  always_comb begin
    px_s     = {1'b0, pixelX};
    py_s     = {1'b0, pixelY};
    dx_s     = pixelX - x_r[10:0];
    dy_s     = pixelY - y_r[10:0];
    inside_s = (state_r != DEAD) &&
               (px_s >= x_r) && (px_s <= x_r + W - 12'd1) &&
               (py_s >= y_r) && (py_s <= y_r + H - 12'd1);
  end

  // State, position and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= MOVE_RIGHT;
      dir_r    <= 1'b1;
      x_r      <= IX;
      y_r      <= IY;
      cnt_r    <= 16'd0;
      alive_r  <= 1'b1;
      landed_r <= 1'b0;
      inside_r <= 1'b0;
      offx_r   <= 11'd0;
      offy_r   <= 11'd0;
    end else begin
      state_r  <= state_s;
      dir_r    <= dir_s;
      x_r      <= x_s;
      y_r      <= y_s;
      cnt_r    <= cnt_s;
      alive_r  <= (state_s != DEAD);
      landed_r <= (state_s == LANDED);
      inside_r <= inside_s;
      offx_r   <= inside_s ? dx_s : 11'd0;
      offy_r   <= inside_s ? dy_s : 11'd0;
    end
  end

  assign topLeftX        = x_r[10:0];
  assign topLeftY        = y_r[10:0];
  assign alive           = alive_r;
  assign reachedBottom   = landed_r;
  assign InsideRectangle = inside_r;
  assign offsetX         = offx_r;
  assign offsetY         = offy_r;

endmodule

// File: tb/tb_enemy_move_square.sv
// Randomized bench for enemy_move_square against a frame-level behavioural model,
// with hand-computed pins on reset, motion, hit test, death/respawn and landing.
module tb_enemy_move_square;

  localparam int W  = 11;
  localparam int H  = 48;
  localparam int IX = 40;
  localparam int IY = 32;
  localparam int SP = 2;
  localparam int DY = 16;
  localparam int LL = 4;
  localparam int RL = 99;
  localparam int BL = 159;
  localparam int RF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        hit = 1'b0;
  logic [10:0] pixelX = 11'd0;
  logic [10:0] pixelY = 11'd0;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
  logic        InsideRectangle, alive, reachedBottom;

  enemy_move_square #(
    .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H), .INIT_X(IX), .INIT_Y(IY),
    .SPEED_X(SP), .DROP_Y(DY), .LEFT_LIMIT(LL), .RIGHT_LIMIT(RL),
    .BOTTOM_LIMIT(BL), .RESPAWN_FRAMES(RF)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .hit(hit),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .alive(alive),
    .reachedBottom(reachedBottom)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: phase is one of "right", "left", "drop", "dead", "landed".
  string mph = "right";
  int mx = IX, my = IY, mcnt = 0, mox = 0, moy = 0;
  bit mdir = 1'b1, mins = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit h, input int px, input int py);
    bit live;
    if (r) begin
      mph = "right"; mx = IX; my = IY; mdir = 1'b1; mcnt = 0;
      mins = 1'b0; mox = 0; moy = 0;
    end else begin
      live = (mph != "dead");
      mins = live && px >= mx && px < mx + W && py >= my && py < my + H;
      mox  = mins ? px - mx : 0;
      moy  = mins ? py - my : 0;
      if (h && (mph == "right" || mph == "left" || mph == "drop")) begin
        mph = "dead"; mcnt = RF;
      end else if (s) begin
        if (mph == "right") begin
          if (mx + SP + W - 1 > RL) begin mx = RL - W + 1; mdir = !mdir; mph = "drop"; end
          else mx = mx + SP;
        end else if (mph == "left") begin
          if (mx < LL + SP) begin mx = LL; mdir = !mdir; mph = "drop"; end
          else mx = mx - SP;
        end else if (mph == "drop") begin
          if (my + DY + H - 1 > BL) begin my = BL - H + 1; mph = "landed"; end
          else begin my = my + DY; mph = mdir ? "right" : "left"; end
        end else if (mph == "dead") begin
          if (mcnt != 0) mcnt--;
          else begin mx = IX; my = IY; mdir = 1'b1; mph = "right"; end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 ns later.
  task automatic step(input bit r, input bit s, input bit h, input int px, input int py);
    reset = r; startOfFrame = s; hit = h;
    pixelX = 11'(px); pixelY = 11'(py);
    @(posedge clk);
    model_edge(r, s, h, px, py);
    #1;
    chk("topLeftX", int'(topLeftX), mx);
    chk("topLeftY", int'(topLeftY), my);
    chk("alive", int'(alive), (mph != "dead") ? 1 : 0);
    chk("reachedBottom", int'(reachedBottom), (mph == "landed") ? 1 : 0);
    chk("InsideRectangle", int'(InsideRectangle), int'(mins));
    chk("offsetX", int'(offsetX), mox);
    chk("offsetY", int'(offsetY), moy);
  endtask

  initial begin
    int px, py, land_x;
    bit s, h;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
    chk("pin_reset_x", int'(topLeftX), 40);
    chk("pin_reset_y", int'(topLeftY), 32);
    chk("pin_reset_alive", int'(alive), 1);
    chk("pin_reset_inside", int'(InsideRectangle), 0);
    chk("pin_reset_offx", int'(offsetX), 0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("pin_5frames_x", int'(topLeftX), 50);
    chk("pin_5frames_y", int'(topLeftY), 32);

    step(1'b0, 1'b0, 1'b0, 52, 40);
    chk("pin_inside", int'(InsideRectangle), 1);
    chk("pin_offx", int'(offsetX), 2);
    chk("pin_offy", int'(offsetY), 8);
    step(1'b0, 1'b0, 1'b0, 61, 40);
    chk("pin_outside_right", int'(InsideRectangle), 0);

    step(1'b0, 1'b1, 1'b1, 52, 40);
    chk("pin_hit_x_held", int'(topLeftX), 50);
    chk("pin_hit_dead", int'(alive), 0);
    step(1'b0, 1'b0, 1'b0, 52, 40);
    chk("pin_dead_inside", int'(InsideRectangle), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("pin_still_dead", int'(alive), 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("pin_respawn_alive", int'(alive), 1);
    chk("pin_respawn_x", int'(topLeftX), 40);
    chk("pin_respawn_y", int'(topLeftY), 32);

    step(1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    chk("pin_reset_dead_alive", int'(alive), 1);
    chk("pin_reset_dead_x", int'(topLeftX), 40);
    chk("pin_reset_dead_y", int'(topLeftY), 32);

    // Random phase: pixels scanned around the sprite, sparse frames and hits.
    for (int i = 0; i < 3000; i++) begin
      px = mx + int'($urandom_range(0, W + 3)) - 2;
      py = my + int'($urandom_range(0, H + 3)) - 2;
      s  = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 149) == 0);
      step(($urandom_range(0, 999) == 0), s, h, px, py);
    end

    // Drive frames until the sprite lands.
    for (int i = 0; i < 3000 && mph != "landed"; i++) begin
      px = mx + int'($urandom_range(0, W + 3)) - 2;
      py = my + int'($urandom_range(0, H + 3)) - 2;
      step(1'b0, ($urandom_range(0, 1) == 0), 1'b0, px, py);
    end
    chk("landing_reached_in_budget", (mph == "landed") ? 1 : 0, 1);
    chk("pin_landed_flag", int'(reachedBottom), 1);
    chk("pin_landed_y", int'(topLeftY), 112);
    land_x = int'(topLeftX);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, land_x + 3, 120);
    chk("pin_landed_x_hold", int'(topLeftX), land_x);
    chk("pin_landed_y_hold", int'(topLeftY), 112);
    chk("pin_landed_alive", int'(alive), 1);
    chk("pin_landed_visible", int'(InsideRectangle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
